ntt_out_stream: RTL and testbench

NTT_OUT_STREAM -- requirements
Module: ntt_out_stream

---
 rtl/ntt_pkg.sv | 12 +
 rtl/ntt_out_buf.sv | 28 ++
 rtl/ntt_out_stream.sv | 115 +++++++++++
 tb/tb_ntt_out_stream.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and state encoding for the NTT result streaming block.
package ntt_pkg;

    localparam int N      = 64;
    localparam int DATA_W = 64;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/ntt_out_buf.sv
// Holding buffer for one NTT result vector: parallel load, indexed read.
module ntt_out_buf #(
    parameter int  N      = 64,
    parameter int  DATA_W = 64,
    localparam int IDX_W  = $clog2(N)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [N-1:0][DATA_W-1:0]   din,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [DATA_W-1:0]          rd_data
);

    logic [N-1:0][DATA_W-1:0] mem_q;

    // Whole vector is captured in one cycle; contents clear on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= '0;
        end else if (load) begin
            mem_q <= din;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/ntt_out_stream.sv
// Captures a parallel NTT result on the rising edge of done and streams it
// out one word per accepted handshake, flagging transforms that arrive early.
module ntt_out_stream #(
    parameter int  N      = ntt_pkg::N,
    parameter int  DATA_W = ntt_pkg::DATA_W,
    localparam int IDX_W  = $clog2(N)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0][DATA_W-1:0]   y,
    input  logic                       done,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic [IDX_W-1:0]           m_index,
    output logic                       busy,
    output logic                       overrun
);

    import ntt_pkg::state_t;
    import ntt_pkg::IDLE;
    import ntt_pkg::STREAM;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_p1;
    logic               armed_q;
    logic               overrun_q;
    logic               rise;
    logic               load;
    logic [DATA_W-1:0]  rd_data;

    // armed_q blocks a done level that was already high across reset release
    // from looking like a new edge; it arms once done has been seen low.
    assign rise = done && !done_p1 && armed_q;

    ntt_out_buf #(
        .N      (N),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .din     (y),
        .rd_idx  (idx_q),
        .rd_data (rd_data)
    );

    // State and word index registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: capture on an edge in IDLE, advance on each handshake in STREAM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Edge-detect history and the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            done_p1   <= 1'b0;
            armed_q   <= !done;
            overrun_q <= 1'b0;
        end else begin
            done_p1 <= done;
            armed_q <= armed_q | !done;
            if (rise && (state_q == STREAM)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign m_valid = (state_q == STREAM);
    assign busy    = m_valid;
    assign m_data  = m_valid ? rd_data : '0;
    assign m_index = idx_q;
    assign m_last  = m_valid && (idx_q == LAST_IDX);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_ntt_out_stream.sv
// Directed bench for ntt_out_stream with hand-derived expected streams.
module tb_ntt_out_stream;

    localparam int N      = 64;
    localparam int DATA_W = 64;
    localparam int IDX_W  = 6;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [N-1:0][DATA_W-1:0]   y;
    logic                       done;
    logic [DATA_W-1:0]          m_data;
    logic                       m_valid;
    logic                       m_ready;
    logic                       m_last;
    logic [IDX_W-1:0]           m_index;
    logic                       busy;
    logic                       overrun;

    int n_cmp = 0;
    int n_bad = 0;

    ntt_out_stream #(.N(N), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .y       (y),
        .done    (done),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .m_index (m_index),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic load_y_base();
        for (int i = 0; i < N; i++) y[i] = DATA_W'(i + 100);
    endtask

    task automatic test_reset();
        rst = 1'b0; done = 1'b0; m_ready = 1'b0; y = '1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({m_valid, m_last, m_index, m_data, busy, overrun} !== '0) begin
            n_bad++;
            $display("FAIL reset: got v=%0b l=%0b idx=%0d d=%0h busy=%0b ovr=%0b, want all 0",
                     m_valid, m_last, m_index, m_data, busy, overrun);
        end
        rst = 1'b1;
        load_y_base();
    endtask

    task automatic test_full_stream();
        logic [DATA_W+IDX_W+2:0] want;
        @(negedge clk);
        done = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            want = {1'b1, 1'(i == N - 1), IDX_W'(i), DATA_W'(i + 100), 1'b1};
            n_cmp++;
            if ({m_valid, m_last, m_index, m_data, busy} !== want) begin
                n_bad++;
                $display("FAIL full_stream[%0d]: got v=%0b l=%0b idx=%0d d=%0d, want idx=%0d d=%0d",
                         i, m_valid, m_last, m_index, m_data, i, i + 100);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({m_valid, m_last, m_index, m_data, busy} !== '0) begin
            n_bad++;
            $display("FAIL full_stream_idle: got v=%0b l=%0b idx=%0d d=%0d busy=%0b, want all 0",
                     m_valid, m_last, m_index, m_data, busy);
        end
        done = 1'b0;
    endtask

    task automatic test_backpressure();
        int  exp_i = 0;
        int  cyc   = 0;
        logic tog  = 1'b1;
        @(negedge clk);
        done = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        done = 1'b0;
        while (exp_i < N && cyc < 300) begin
            n_cmp++;
            if ({m_valid, m_last, m_index, m_data} !==
                {1'b1, 1'(exp_i == N - 1), IDX_W'(exp_i), DATA_W'(exp_i + 100)}) begin
                n_bad++;
                $display("FAIL backpressure[%0d]: got v=%0b l=%0b idx=%0d d=%0d, want idx=%0d d=%0d",
                         cyc, m_valid, m_last, m_index, m_data, exp_i, exp_i + 100);
            end
            m_ready = tog;
            if (tog) exp_i++;
            tog = ~tog;
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (exp_i != N || m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure_end: got transfers=%0d v=%0b, want transfers=%0d v=0",
                     exp_i, m_valid, N);
        end
        m_ready = 1'b1;
    endtask

    task automatic test_overrun();
        @(negedge clk);
        done = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({m_valid, m_index, m_data, overrun} !==
                {1'b1, IDX_W'(i), DATA_W'(i + 100), 1'(i > 20)}) begin
                n_bad++;
                $display("FAIL overrun[%0d]: got v=%0b idx=%0d d=%0h ovr=%0b, want idx=%0d d=%0h ovr=%0b",
                         i, m_valid, m_index, m_data, overrun, i, i + 100, (i > 20));
            end
            if (i == 0) done = 1'b0;
            if (i == 20) begin
                y    = '1;
                done = 1'b1;
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({m_valid, busy, overrun} !== 3'b001) begin
            n_bad++;
            $display("FAIL overrun_end: got v=%0b busy=%0b ovr=%0b, want v=0 busy=0 ovr=1",
                     m_valid, busy, overrun);
        end
        done = 1'b0;
        load_y_base();
    endtask

    task automatic test_done_held();
        int cnt = 0;
        @(negedge clk);
        done = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (m_valid) begin
                n_cmp++;
                if ({m_index, m_data} !== {IDX_W'(cnt), DATA_W'(cnt + 100)}) begin
                    n_bad++;
                    $display("FAIL done_held[%0d]: got idx=%0d d=%0d, want idx=%0d d=%0d",
                             c, m_index, m_data, cnt, cnt + 100);
                end
                cnt++;
            end
        end
        n_cmp++;
        if (cnt != N) begin
            n_bad++;
            $display("FAIL done_held_count: got %0d words, want %0d", cnt, N);
        end
        done = 1'b0;
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        done = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({m_valid, m_index, m_data} !== {1'b1, IDX_W'(i), DATA_W'(i + 100)}) begin
                n_bad++;
                $display("FAIL midreset_pre[%0d]: got v=%0b idx=%0d d=%0d, want idx=%0d d=%0d",
                         i, m_valid, m_index, m_data, i, i + 100);
            end
            if (i == 0) done = 1'b0;
            if (i == 30) rst = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if ({m_valid, busy, overrun, m_last, m_index, m_data} !== '0) begin
            n_bad++;
            $display("FAIL midreset_clear: got v=%0b busy=%0b ovr=%0b idx=%0d d=%0d, want all 0",
                     m_valid, busy, overrun, m_index, m_data);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_quiet: got v=%0b, want 0", m_valid);
        end
        done = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({m_valid, m_last, m_index, m_data, overrun} !==
                {1'b1, 1'(i == N - 1), IDX_W'(i), DATA_W'(i + 100), 1'b0}) begin
                n_bad++;
                $display("FAIL midreset_restream[%0d]: got v=%0b idx=%0d d=%0d ovr=%0b, want idx=%0d d=%0d ovr=0",
                         i, m_valid, m_index, m_data, overrun, i, i + 100);
            end
        end
        done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_last_edge();
        @(negedge clk);
        done = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({m_valid, m_index, overrun} !== {1'b1, IDX_W'(i), 1'b0}) begin
                n_bad++;
                $display("FAIL last_edge_stream[%0d]: got v=%0b idx=%0d ovr=%0b, want idx=%0d ovr=0",
                         i, m_valid, m_index, overrun, i);
            end
            if (i == 0) done = 1'b0;
            if (i == N - 1) done = 1'b1;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({m_valid, busy, overrun} !== 3'b001) begin
                n_bad++;
                $display("FAIL last_edge_after[%0d]: got v=%0b busy=%0b ovr=%0b, want v=0 busy=0 ovr=1",
                         c, m_valid, busy, overrun);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_done_at_release();
        @(negedge clk);
        rst = 1'b0; done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({m_valid, busy} !== 2'b00) begin
                n_bad++;
                $display("FAIL release_high[%0d]: got v=%0b busy=%0b, want 0 0", c, m_valid, busy);
            end
        end
        done = 1'b0;
        @(negedge clk);
        done = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({m_valid, m_last, m_index, m_data, overrun} !==
                {1'b1, 1'(i == N - 1), IDX_W'(i), DATA_W'(i + 100), 1'b0}) begin
                n_bad++;
                $display("FAIL release_stream[%0d]: got v=%0b l=%0b idx=%0d d=%0d ovr=%0b, want idx=%0d d=%0d",
                         i, m_valid, m_last, m_index, m_data, overrun, i, i + 100);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL release_end: got v=%0b, want 0", m_valid);
        end
        done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_backpressure();
        test_overrun();
        test_done_held();
        test_reset_midstream();
        test_last_edge();
        test_done_at_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
